uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- Receive-side command reader for the UART port pair (rxdata/rxready/rxclk) on the board top level.
- Pops bytes from the UART receiver with a one-cycle rxclk acknowledge and parses a small ASCII command set.
- Drives the animation pattern select (ctrl) and the clock-divider limit (divider) with the same step and clamp rules as the pushbutton path, so a host terminal can control the idle animation.

Parameters:
- DIV_DEFAULT, 2, divider value after reset and after the 'R' command.
- DIV_STEP, 2, increment/decrement applied by '+' / '-'.
- DIV_MAX, 20, upper clamp for divider.
- ARG_TIMEOUT, 200, cycles allowed in ARG state before abort (2 s at hz100).

Ports:
- hz100  in  1  system clock (100 Hz board clock).
- reset  in  1  asynchronous, active-high reset.
- rxdata  in  8  received byte; stable while rxready is high.
- rxready  in  1  byte available; asynchronous to hz100.
- rxclk  out  1  one-cycle acknowledge/pop pulse to the UART receiver.
- ctrl  out  3  animation pattern select.
- divider  out  8  clock divider limit.
- cmd_ok  out  1  one-cycle pulse when a command completes successfully.
- cmd_err  out  1  one-cycle pulse on an invalid byte, invalid argument or timeout.
- byte_cnt  out  8  count of accepted bytes; wraps 255 -> 0.

Behaviour:
- Clock and reset are fixed as decided: one clock, hz100; reset is asynchronous and active-high.
- Reset values: rxclk=0, ctrl=0, divider=DIV_DEFAULT, cmd_ok=0, cmd_err=0, byte_cnt=0. Both FSMs go to their idle states (IDLE, CMD), the synchronizer clears, and the timeout counter is 0.
- rxready passes through a 2-FF synchronizer (rx_s).

Handshake FSM:
- IDLE: when rx_s=1, capture rxdata into byte_q, set rxclk<=1, byte_cnt<=byte_cnt+1, set byte_new, go to WAIT_LOW.
- WAIT_LOW: rxclk<=0 on the first cycle. Stay until rx_s=0, then return to IDLE.
- Exactly one capture per rxready high period. A rxready held high indefinitely produces exactly one rxclk pulse.
- Latency: rxready high before edge 0 -> rx_s high after edge 1 -> capture and rxclk=1 after edge 2 -> rxclk=0 and decode result visible after edge 3.

Parser FSM (acts on byte_new, one cycle after capture):
- CMD, 0x50 'P': go to ARG, clear timeout counter. No pulse yet.
- CMD, 0x2B '+': if divider >= DIV_MAX-1 then divider<=DIV_MAX, else divider<=divider+DIV_STEP. Pulse cmd_ok.
- CMD, 0x2D '-': if divider <= DIV_STEP then divider<=0, else divider<=divider-DIV_STEP. Pulse cmd_ok.
- CMD, 0x52 'R': ctrl<=0, divider<=DIV_DEFAULT. Pulse cmd_ok.
- CMD, 0x0D or 0x0A: ignored, no pulse.
- CMD, any other byte: pulse cmd_err, stay in CMD.
- ARG, byte 0x30..0x37: ctrl<=byte_q[2:0], pulse cmd_ok, go to CMD.
- ARG, any other byte: pulse cmd_err, ctrl unchanged, go to CMD. The byte is not reinterpreted as a command.
- ARG, no byte_new: timeout counter increments each cycle. When it reaches ARG_TIMEOUT-1, pulse cmd_err, go to CMD, clear the counter.
- Simultaneous byte_new and timeout expiry: the byte wins and is processed as the argument.
- cmd_ok and cmd_err are never high in the same cycle. Each is high for exactly one cycle per event.
- Arithmetic is 8-bit unsigned. divider never leaves [0, DIV_MAX] via commands.
- Reset asserted mid-handshake (rxclk high) or mid-ARG: all state returns to reset values immediately. A rxready still high after reset releases is accepted as a new byte.

Test Plan:
- Reset, then idle 10 cycles -> ctrl=0, divider=2, rxclk=0, byte_cnt=0, no pulses.
- Send 'P' then '5' (each: rxready high 5 cycles, rxdata stable) -> one rxclk pulse per byte, exactly 2 cycles after rxready rises; ctrl=5; cmd_ok once; byte_cnt=2.
- Send '+' 10 times from divider=2 -> 4,6,...,20, then stays 20 on the 10th; 10 cmd_ok pulses. Then send '-' 11 times -> reaches 0 and stays 0.
- Send 'P','9' -> cmd_err once, ctrl unchanged. Send 'X' -> cmd_err. Send 0x0D -> no pulse.
- Send 'P', then nothing for 200 cycles -> cmd_err exactly at timeout. A following '3' gives a CMD-state cmd_err and ctrl is unchanged.
- Hold rxready high 50 cycles -> a single rxclk pulse. Assert reset while rxclk=1 -> all outputs at reset values on the same edge. Send 'R' after '+','+','P','4' -> ctrl=0, divider=2.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// UART receive-side command reader: pops bytes with a one-cycle rxclk acknowledge
// and parses single-byte ASCII commands that drive the animation select and divider.
module uart_cmd_rx #(
  parameter int unsigned DIV_DEFAULT = 2,
  parameter int unsigned DIV_STEP    = 2,
  parameter int unsigned DIV_MAX     = 20,
  parameter int unsigned ARG_TIMEOUT = 200
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic [7:0] rxdata,
  input  logic       rxready,
  output logic       rxclk,
  output logic [2:0] ctrl,
  output logic [7:0] divider,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic [7:0] byte_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned TW = (ARG_TIMEOUT > 2) ? $clog2(ARG_TIMEOUT) : 1;

  localparam logic [DW-1:0] DIV_DEF  = DW'(DIV_DEFAULT);
  localparam logic [DW-1:0] DIV_INC  = DW'(DIV_STEP);
  localparam logic [DW-1:0] DIV_TOP  = DW'(DIV_MAX);
  localparam logic [DW-1:0] DIV_TOP1 = DW'(DIV_MAX - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ARG_TIMEOUT - 1);

  typedef enum logic {HS_IDLE, HS_WAIT_LOW} hs_e;
  typedef enum logic {PS_CMD, PS_ARG} ps_e;

  logic          rx_meta_q, rx_s_q;
  hs_e           hs_q, hs_d;
  logic [DW-1:0] byte_q, byte_d;
  logic          rxclk_q, rxclk_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          new_q, new_d;
  ps_e           ps_q, ps_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] div_q, div_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;

  // State registers, including the rxready synchronizer
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
      hs_q      <= HS_IDLE;
      byte_q    <= '0;
      rxclk_q   <= 1'b0;
      cnt_q     <= '0;
      new_q     <= 1'b0;
      ps_q      <= PS_CMD;
      tmo_q     <= '0;
      ctrl_q    <= '0;
      div_q     <= DIV_DEF;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rxready;
      rx_s_q    <= rx_meta_q;
      hs_q      <= hs_d;
      byte_q    <= byte_d;
      rxclk_q   <= rxclk_d;
      cnt_q     <= cnt_d;
      new_q     <= new_d;
      ps_q      <= ps_d;
      tmo_q     <= tmo_d;
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  // Handshake: one capture per synchronized rxready high period
  always_comb begin
    hs_d    = hs_q;
    byte_d  = byte_q;
    rxclk_d = 1'b0;
    cnt_d   = cnt_q;
    new_d   = 1'b0;
    case (hs_q)
      HS_IDLE: begin
        if (rx_s_q) begin
          byte_d  = rxdata;
          rxclk_d = 1'b1;
          cnt_d   = cnt_q + DW'(1);
          new_d   = 1'b1;
          hs_d    = HS_WAIT_LOW;
        end
      end
      HS_WAIT_LOW: begin
        if (!rx_s_q) hs_d = HS_IDLE;
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  // Parser: a fresh byte always takes priority over the argument timeout
  always_comb begin
    ps_d   = ps_q;
    tmo_d  = tmo_q;
    ctrl_d = ctrl_q;
    div_d  = div_q;
    ok_d   = 1'b0;
    err_d  = 1'b0;
    case (ps_q)
      PS_CMD: begin
        if (new_q) begin
          case (byte_q)
            8'h50: begin
              ps_d  = PS_ARG;
              tmo_d = '0;
            end
            8'h2B: begin
              div_d = (div_q >= DIV_TOP1) ? DIV_TOP : div_q + DIV_INC;
              ok_d  = 1'b1;
            end
            8'h2D: begin
              div_d = (div_q <= DIV_INC) ? '0 : div_q - DIV_INC;
              ok_d  = 1'b1;
            end
            8'h52: begin
              ctrl_d = '0;
              div_d  = DIV_DEF;
              ok_d   = 1'b1;
            end
            8'h0D, 8'h0A: begin
              ok_d = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      PS_ARG: begin
        if (new_q) begin
          if (byte_q[7:3] == 5'b00110) begin
            ctrl_d = byte_q[2:0];
            ok_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          ps_d  = PS_CMD;
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_d = 1'b1;
          ps_d  = PS_CMD;
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ps_d = PS_CMD;
    endcase
  end

  assign rxclk    = rxclk_q;
  assign ctrl     = ctrl_q;
  assign divider  = div_q;
  assign cmd_ok   = ok_q;
  assign cmd_err  = err_q;
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: a byte-level reference model pushes expected
// command results to a queue; a monitor pops them when cmd_ok/cmd_err pulse.
module tb_uart_cmd_rx;

  logic       hz100 = 1'b0;
  logic       reset;
  logic [7:0] rxdata;
  logic       rxready;
  logic       rxclk;
  logic [2:0] ctrl;
  logic [7:0] divider;
  logic       cmd_ok;
  logic       cmd_err;
  logic [7:0] byte_cnt;

  uart_cmd_rx dut (
    .hz100   (hz100),
    .reset   (reset),
    .rxdata  (rxdata),
    .rxready (rxready),
    .rxclk   (rxclk),
    .ctrl    (ctrl),
    .divider (divider),
    .cmd_ok  (cmd_ok),
    .cmd_err (cmd_err),
    .byte_cnt(byte_cnt)
  );

  always #5 hz100 = ~hz100;

  typedef struct {
    logic       ok;
    logic [2:0] ctrl;
    logic [7:0] div;
    int         at;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rx_pulses = 0;
  int n_ok = 0;
  int t_dec = 0;
  logic rxclk_prev = 1'b0;

  logic [2:0] m_ctrl;
  logic [7:0] m_div;
  logic [7:0] m_cnt;
  bit         m_arg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic void push(input logic ok, input int at);
    exp_t e;
    e.ok   = ok;
    e.ctrl = m_ctrl;
    e.div  = m_div;
    e.at   = at;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_ctrl = 3'd0;
    m_div  = 8'd2;
    m_cnt  = 8'd0;
    m_arg  = 1'b0;
  endfunction

  // Reference behaviour of one accepted byte
  function automatic void model(input logic [7:0] b);
    m_cnt = m_cnt + 8'd1;
    if (m_arg) begin
      m_arg = 1'b0;
      if (b >= 8'h30 && b <= 8'h37) begin
        m_ctrl = b[2:0];
        push(1'b1, 0);
      end else begin
        push(1'b0, 0);
      end
    end else begin
      case (b)
        8'h50: m_arg = 1'b1;
        8'h2B: begin
          m_div = (m_div >= 8'd19) ? 8'd20 : m_div + 8'd2;
          push(1'b1, 0);
        end
        8'h2D: begin
          m_div = (m_div <= 8'd2) ? 8'd0 : m_div - 8'd2;
          push(1'b1, 0);
        end
        8'h52: begin
          m_ctrl = 3'd0;
          m_div  = 8'd2;
          push(1'b1, 0);
        end
        8'h0D, 8'h0A: m_arg = 1'b0;
        default: push(1'b0, 0);
      endcase
    end
  endfunction

  always @(posedge hz100) cyc++;

  // Monitor: count rxclk pulses and score every result pulse
  always @(negedge hz100) begin
    exp_t e;
    if (rxclk && !rxclk_prev) rx_pulses++;
    rxclk_prev = rxclk;
    if (cmd_ok) n_ok++;
    if (cmd_ok || cmd_err) begin
      check("ok_err_exclusive", 32'(cmd_ok & cmd_err), 32'd0);
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'({cmd_ok, cmd_err}), 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", 32'({cmd_ok, cmd_err}), e.ok ? 32'd2 : 32'd1);
        check("pulse_ctrl", 32'(ctrl), 32'(e.ctrl));
        check("pulse_div", 32'(divider), 32'(e.div));
        if (e.at != 0) check("pulse_time", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Drive one byte for 'hold' cycles, checking acknowledge latency and the drain
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge hz100);
    rxdata  = b;
    rxready = 1'b1;
    model(b);
    @(negedge hz100);
    @(negedge hz100);
    check("rxclk_lat1", 32'(rxclk), 32'd0);
    @(negedge hz100);
    check("rxclk_lat2", 32'(rxclk), 32'd1);
    @(negedge hz100);
    check("rxclk_lat3", 32'(rxclk), 32'd0);
    t_dec = cyc;
    repeat (hold - 4) @(negedge hz100);
    rxready = 1'b0;
    repeat (4) @(negedge hz100);
    check("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int p0;
    int k0;
    reset   = 1'b1;
    rxready = 1'b0;
    rxdata  = 8'h00;
    model_reset();
    repeat (3) @(negedge hz100);
    reset = 1'b0;
    repeat (10) @(negedge hz100);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_div", 32'(divider), 32'd2);
    check("rst_rxclk", 32'(rxclk), 32'd0);
    check("rst_cnt", 32'(byte_cnt), 32'd0);
    check("rst_ok", 32'(cmd_ok), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);

    // Pattern select
    p0 = rx_pulses;
    k0 = n_ok;
    send_byte(8'h50, 5);
    send_byte(8'h35, 5);
    check("p5_ctrl", 32'(ctrl), 32'd5);
    check("p5_cnt", 32'(byte_cnt), 32'd2);
    check("p5_rxclk_pulses", 32'(rx_pulses - p0), 32'd2);
    check("p5_ok_pulses", 32'(n_ok - k0), 32'd1);

    // Divider clamp up, then clamp down
    k0 = n_ok;
    for (int i = 0; i < 10; i++) send_byte(8'h2B, 5);
    check("plus_clamp", 32'(divider), 32'd20);
    check("plus_ok_pulses", 32'(n_ok - k0), 32'd10);
    for (int i = 0; i < 11; i++) send_byte(8'h2D, 5);
    check("minus_clamp", 32'(divider), 32'd0);

    // Bad argument, unknown command, ignored CR
    send_byte(8'h50, 5);
    send_byte(8'h39, 5);
    check("badarg_ctrl", 32'(ctrl), 32'd5);
    send_byte(8'h58, 5);
    send_byte(8'h0D, 5);

    // Argument timeout, then a digit seen as a command
    send_byte(8'h50, 5);
    m_arg = 1'b0;
    push(1'b0, t_dec + 200);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge hz100);
    check("tmo_seen", 32'(q.size()), 32'd0);
    send_byte(8'h33, 5);
    check("tmo_ctrl", 32'(ctrl), 32'd5);

    // Long rxready high gives a single acknowledge
    p0 = rx_pulses;
    send_byte(8'h0D, 50);
    check("hold_single_pulse", 32'(rx_pulses - p0), 32'd1);

    // Reset while rxclk is high; rxready held through release is re-accepted
    send_byte(8'h2B, 5);
    send_byte(8'h2B, 5);
    send_byte(8'h50, 5);
    send_byte(8'h36, 5);
    @(negedge hz100);
    rxdata  = 8'h2B;
    rxready = 1'b1;
    repeat (3) @(negedge hz100);
    check("pre_rst_rxclk", 32'(rxclk), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_rxclk", 32'(rxclk), 32'd0);
    check("mid_rst_ctrl", 32'(ctrl), 32'd0);
    check("mid_rst_div", 32'(divider), 32'd2);
    check("mid_rst_cnt", 32'(byte_cnt), 32'd0);
    check("mid_rst_pulses", 32'({cmd_ok, cmd_err}), 32'd0);
    model_reset();
    @(negedge hz100);
    reset = 1'b0;
    model(8'h2B);
    repeat (6) @(negedge hz100);
    check("rerx_cnt", 32'(byte_cnt), 32'd1);
    check("rerx_div", 32'(divider), 32'd4);
    check("rerx_drain", 32'(q.size()), 32'd0);
    rxready = 1'b0;
    repeat (4) @(negedge hz100);

    // 'R' restores defaults
    send_byte(8'h2B, 5);
    send_byte(8'h2B, 5);
    send_byte(8'h50, 5);
    send_byte(8'h34, 5);
    check("pre_r_ctrl", 32'(ctrl), 32'd4);
    check("pre_r_div", 32'(divider), 32'd8);
    send_byte(8'h52, 5);
    check("r_ctrl", 32'(ctrl), 32'd0);
    check("r_div", 32'(divider), 32'd2);

    repeat (5) @(negedge hz100);
    check("final_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
